// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster generator: (x, y) pixel requests, latency-matched sync/blank/RGB pins.
// Defining VGA_TEST_PATTERN_EN adds a test_mode input selecting an internal 8-bar colour pattern.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          H_POL    = 1'b0,
    parameter bit          V_POL    = 1'b0,
    parameter int unsigned PIX_LAT  = 1,
    parameter int unsigned COLOR_W  = 8
) (
    input  logic                                              clk,
    input  logic                                              reset,
    input  logic                                              pix_en,
    input  logic [COLOR_W-1:0]                                pix_r,
    input  logic [COLOR_W-1:0]                                pix_g,
    input  logic [COLOR_W-1:0]                                pix_b,
`ifdef VGA_TEST_PATTERN_EN
    input  logic                                              test_mode,
`endif
    output logic [$clog2(H_ACTIVE+H_FP+H_SYNC+H_BP)-1:0]     x,
    output logic [$clog2(V_ACTIVE+V_FP+V_SYNC+V_BP)-1:0]     y,
    output logic                                              req,
    output logic                                              frame_start,
    output logic                                              h_sync,
    output logic                                              v_sync,
    output logic                                              blank_n,
    output logic                                              sync_n,
    output logic [COLOR_W-1:0]                                red,
    output logic [COLOR_W-1:0]                                green,
    output logic [COLOR_W-1:0]                                blue
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_END = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEGIN  = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END    = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_END = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEGIN  = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END    = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

    localparam logic HS_OFF = ~H_POL;
    localparam logic VS_OFF = ~V_POL;

`ifdef VGA_TEST_PATTERN_EN
    localparam int unsigned DW = 7;
`else
    localparam int unsigned DW = 4;
`endif

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_en) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    logic h_act, v_act, hs_dec, vs_dec, first;
    logic [DW-1:0] dec;
    logic [DW-1:0] tap;

    assign h_act  = h_cnt < H_ACT_END;
    assign v_act  = v_cnt < V_ACT_END;
    assign hs_dec = (h_cnt >= HS_BEGIN) && (h_cnt <= HS_END);
    assign vs_dec = (v_cnt >= VS_BEGIN) && (v_cnt <= VS_END);
    assign first  = (h_cnt == '0) && (v_cnt == '0);

    assign x       = h_cnt;
    assign y       = v_cnt;
    assign req     = pix_en & h_act & v_act;
    assign sync_n  = 1'b0;

`ifdef VGA_TEST_PATTERN_EN
    localparam int unsigned BAR_W = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;

    logic [HW-1:0] bar_idx;
    logic [2:0]    bar_rgb;

    assign bar_idx = h_cnt / HW'(BAR_W);

    // {r, g, b} masks: white, yellow, cyan, green, magenta, red, blue, black
    always_comb begin
        bar_rgb = 3'b000;
        case (bar_idx)
            HW'(0):  bar_rgb = 3'b111;
            HW'(1):  bar_rgb = 3'b110;
            HW'(2):  bar_rgb = 3'b011;
            HW'(3):  bar_rgb = 3'b010;
            HW'(4):  bar_rgb = 3'b101;
            HW'(5):  bar_rgb = 3'b100;
            HW'(6):  bar_rgb = 3'b001;
            default: bar_rgb = 3'b000;
        endcase
    end

    assign dec = {bar_rgb, first, vs_dec, hs_dec, h_act & v_act};
`else
    assign dec = {first, vs_dec, hs_dec, h_act & v_act};
`endif

    // Delay the decode so it meets the source's RGB for the same request at the output register.
    if (PIX_LAT == 0) begin : g_no_dly
        assign tap = dec;
    end else begin : g_dly
        logic [DW-1:0] pipe_q [PIX_LAT];

        always_ff @(posedge clk) begin
            if (reset) begin
                for (int i = 0; i < PIX_LAT; i++) begin
                    pipe_q[i] <= '0;
                end
            end else if (pix_en) begin
                pipe_q[0] <= dec;
                for (int i = 1; i < PIX_LAT; i++) begin
                    pipe_q[i] <= pipe_q[i-1];
                end
            end
        end

        assign tap = pipe_q[PIX_LAT-1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h_sync      <= HS_OFF;
            v_sync      <= VS_OFF;
            blank_n     <= 1'b0;
            frame_start <= 1'b0;
            red         <= '0;
            green       <= '0;
            blue        <= '0;
        end else begin
            frame_start <= pix_en & tap[3];
            if (pix_en) begin
                h_sync  <= tap[1] ? ~HS_OFF : HS_OFF;
                v_sync  <= tap[2] ? ~VS_OFF : VS_OFF;
                blank_n <= tap[0];
                if (tap[0]) begin
`ifdef VGA_TEST_PATTERN_EN
                    if (test_mode) begin
                        red   <= {COLOR_W{tap[6]}};
                        green <= {COLOR_W{tap[5]}};
                        blue  <= {COLOR_W{tap[4]}};
                    end else begin
                        red   <= pix_r;
                        green <= pix_g;
                        blue  <= pix_b;
                    end
`else
                    red   <= pix_r;
                    green <= pix_g;
                    blue  <= pix_b;
`endif
                end else begin
                    red   <= '0;
                    green <= '0;
                    blue  <= '0;
                end
            end
        end
    end

endmodule
